uart_mmio_ctrl: RTL
===================

Name: uart_mmio_ctrl

Overview:
- Memory-mapped controller between the CPU data-memory MMIO path and the UART byte-level receiver/transmitter.
- Buffers received bytes in a small FIFO that drives the receiver's ready/valid handshake.
- Owns a one-byte transmit holding register with valid/ready sequencing toward the transmitter.
- Exposes status, RX data and TX data registers with fixed 1-cycle registered read latency, matching the data memory.

Parameters:
- RX_FIFO_DEPTH, 4, RX byte buffer entries; power of two, >= 2.
- CNT_W, $clog2(RX_FIFO_DEPTH)+1, occupancy counter width (derived; do not override).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- mmio_addr  in  4  byte offset within UART window; only [3:2] decoded.
- mmio_wen  in  1  write strobe, 1 cycle.
- mmio_ren  in  1  read strobe, 1 cycle.
- mmio_wdata  in  32  write data.
- mmio_rdata  out  32  read data, valid the cycle after mmio_ren.
- rx_data  in  8  byte from receiver.
- rx_valid  in  1  receiver has a byte.
- rx_ready  out  1  controller accepts the byte.
- tx_data  out  8  byte to transmitter.
- tx_valid  out  1  holding register full.
- tx_ready  in  1  transmitter accepts the byte.

Behaviour:
- Register map by offset:
  - 0x0 STATUS (R/W1C):
    - bit0 tx_free = holding register empty.
    - bit1 rx_avail = FIFO non-empty.
    - bit2 tx_ovf, sticky.
    - bits[2+CNT_W:3] FIFO count.
    - Other bits read 0.
  - 0x4 RX_DATA (R): returns {24'b0, FIFO head}.
  - 0x8 TX_DATA (W): mmio_wdata[7:0].
  - 0xC reserved: reads return 0, writes are ignored.
- Reset, asynchronous on reset low:
  - FIFO emptied; pointers and count = 0.
  - rx_ready = 1, tx_valid = 0, tx_data = 0, tx_ovf = 0, mmio_rdata = 0.
- RX path:
  - rx_ready = (count != RX_FIFO_DEPTH).
  - Push when rx_valid && rx_ready. Backpressure holds the receiver in its received state, so no byte is ever lost.
  - Read of 0x4 with the FIFO non-empty: pops the head; mmio_rdata shows the popped byte next cycle.
  - Read of 0x4 with the FIFO empty: returns 0, no pop, no pointer change.
  - Push and pop in the same cycle: count unchanged. When count = DEPTH, the push cannot happen because rx_ready = 0. When count = 0, the pop cannot happen; the push proceeds and the read returns 0.
  - Pointers wrap modulo DEPTH.
- TX path, 2-state FSM:
  - TX_IDLE: write of 0x8 loads tx_data and moves to TX_PEND; tx_valid = 1 from the next cycle.
  - TX_PEND: when tx_valid && tx_ready, go to TX_IDLE (tx_valid = 0 next cycle).
  - Write of 0x8 in TX_PEND, including the handshake cycle: byte dropped, tx_ovf set, holding register unchanged.
- Status side effects:
  - Write of 0x0 with wdata[2] = 1 clears tx_ovf.
  - If a set and a clear of tx_ovf land in the same cycle, the set wins.
  - Reads of STATUS have no side effects.
- mmio_rdata:
  - Registered; updated only on cycles with mmio_ren = 1, otherwise it holds.
  - STATUS reflects state before any same-cycle updates.
- mmio_wen and mmio_ren in the same cycle: both actions take effect independently.

Decomposition:
- Shared package uart_mmio_pkg holds:
  - Offset constants UART_STATUS = 4'h0, UART_RX = 4'h4, UART_TX = 4'h8.
  - Status bit indices.
  - TX state encoding: TX_IDLE = 1'b0, TX_PEND = 1'b1.
- Sub-module sync_fifo (parameters WIDTH = 8, DEPTH): push/pop/full/empty/count, same clock and reset. It is reusable for a later TX FIFO.

Test Plan:
- Reset mid-operation (FIFO holding 2, tx_valid = 1) -> next cycle rx_ready = 1, tx_valid = 0; STATUS read returns 0x1.
- Receiver presents 0x41, 0x42 -> STATUS reads 0x2 | (2<<3) | 0x1 = 0x13. RX_DATA reads return 0x41 then 0x42. A third RX_DATA read returns 0 and the count stays 0.
- Five bytes 0x10..0x14 with no reads -> rx_ready = 0 after the 4th push and the 5th stays pending. One RX_DATA read returns 0x10, the 5th byte is then accepted, and subsequent reads return 0x11..0x14 in order.
- TX_DATA write 0x55, tx_ready held 0 for 10 cycles -> tx_valid = 1 with tx_data = 0x55 throughout. A second write of 0xAA sets tx_ovf and tx_data stays 0x55. After tx_ready = 1 for one cycle, tx_valid = 0 and tx_free = 1.
- Write STATUS with 0x4 -> tx_ovf cleared. A TX write in TX_PEND in the same cycle as the W1C -> tx_ovf reads 1.
- Simultaneous push and pop at count = 2 -> count stays 2 and the read returns the oldest byte.

Source files
------------

// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART MMIO controller: register offsets, STATUS
// bit positions, TX holding-register state encoding and an address decode helper.
// Contents: UART_STATUS/UART_RX/UART_TX offsets, ST_* bit indices, tx_state_t, reg_offset().
package uart_mmio_pkg;

  localparam logic [3:0] UART_STATUS = 4'h0;
  localparam logic [3:0] UART_RX     = 4'h4;
  localparam logic [3:0] UART_TX     = 4'h8;

  localparam int ST_TX_FREE   = 0;
  localparam int ST_RX_AVAIL  = 1;
  localparam int ST_TX_OVF    = 2;
  localparam int ST_COUNT_LSB = 3;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_PEND = 1'b1
  } tx_state_t;

  // Only the word-select bits take part in decode; byte-lane bits are ignored.
  function automatic logic [3:0] reg_offset(input logic [3:0] addr);
    return {addr[3:2], 2'b00};
  endfunction

endpackage

// File: rtl/uart_mmio_ctrl_sync_fifo.sv
// sync_fifo: single-clock FIFO with head-of-queue output (first-word fall-through).
// Latency: a pushed word is visible on head the cycle after the push; pop takes effect at the edge.
// Backpressure: push ignored while full, pop ignored while empty; caller gates with full/empty.
// Ports: clk, reset (async active-low), push/push_data, pop, head, full, empty, count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: MMIO register front-end for a UART byte receiver/transmitter.
// Latency: mmio_rdata is registered, valid one cycle after mmio_ren; tx_valid rises the cycle after a TX write.
// Backpressure: rx_ready drops while the RX FIFO is full; TX writes while a byte is pending are dropped and flag tx_ovf.
// Ports: clk, reset (async active-low); mmio_addr/wen/ren/wdata/rdata; rx_data/rx_valid/rx_ready; tx_data/tx_valid/tx_ready.
module uart_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter int RX_FIFO_DEPTH = 4,
  parameter int CNT_W         = $clog2(RX_FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mmio_addr,
  input  logic        mmio_wen,
  input  logic        mmio_ren,
  input  logic [31:0] mmio_wdata,
  output logic [31:0] mmio_rdata,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  logic [3:0]       sel;
  logic             rx_full;
  logic             rx_empty;
  logic [7:0]       rx_head;
  logic [CNT_W-1:0] rx_count;
  logic             rx_pop;
  logic             tx_wr;
  logic             status_wr;
  tx_state_t        tx_state;
  tx_state_t        tx_state_next;
  logic             tx_load;
  logic             ovf_set;
  logic             tx_ovf;
  logic [31:0]      status_word;
  logic [31:0]      rdata_next;

  assign sel       = reg_offset(mmio_addr);
  assign tx_wr     = mmio_wen && (sel == UART_TX);
  assign status_wr = mmio_wen && (sel == UART_STATUS);
  assign rx_pop    = mmio_ren && (sel == UART_RX) && !rx_empty;
  assign rx_ready  = !rx_full;
  assign tx_valid  = (tx_state == TX_PEND);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_valid && rx_ready),
    .push_data (rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  // TX holding register sequencing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
    end else begin
      tx_state <= tx_state_next;
    end
  end

  always_comb begin
    tx_state_next = tx_state;
    tx_load       = 1'b0;
    ovf_set       = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (tx_wr) begin
          tx_load       = 1'b1;
          tx_state_next = TX_PEND;
        end
      end
      TX_PEND: begin
        // A write here is dropped even on the handshake cycle: the old byte
        // is still the one being handed over.
        if (tx_wr)    ovf_set       = 1'b1;
        if (tx_ready) tx_state_next = TX_IDLE;
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data <= '0;
      tx_ovf  <= 1'b0;
    end else begin
      if (tx_load) tx_data <= mmio_wdata[7:0];
      // Set has priority over a same-cycle W1C.
      if (ovf_set) begin
        tx_ovf <= 1'b1;
      end else if (status_wr && mmio_wdata[ST_TX_OVF]) begin
        tx_ovf <= 1'b0;
      end
    end
  end

  // STATUS is built from current state, so a read shows pre-update values.
  always_comb begin
    status_word                           = '0;
    status_word[ST_TX_FREE]               = !tx_valid;
    status_word[ST_RX_AVAIL]              = !rx_empty;
    status_word[ST_TX_OVF]                = tx_ovf;
    status_word[ST_COUNT_LSB +: CNT_W]    = rx_count;
  end

  always_comb begin
    rdata_next = '0;
    case (sel)
      UART_STATUS: rdata_next = status_word;
      UART_RX:     rdata_next = rx_empty ? 32'h0 : {24'h0, rx_head};
      default:     rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mmio_rdata <= '0;
    end else if (mmio_ren) begin
      mmio_rdata <= rdata_next;
    end
  end

endmodule
